// File: rtl/alu_issue_ctrl_if.sv
// Bundle between the EX-stage issue controller, the pipeline front end and the ALU.
// The controller uses the slave modport; the pipeline/ALU side uses master.
interface alu_issue_ctrl_if;
  logic        id_valid;
  logic [3:0]  id_aluop;
  logic [31:0] id_a;
  logic [31:0] id_b;
  logic        id_hilo_we;
  logic        id_mthi;
  logic        id_mtlo;
  logic        issue_ready;
  logic        stall;
  logic [3:0]  alu_aluop;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_res_low;
  logic [31:0] alu_res_high;
  logic        alu_divDone;
  logic [31:0] res;
  logic        res_valid;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_err;

  modport slave (
    input  id_valid, id_aluop, id_a, id_b, id_hilo_we, id_mthi, id_mtlo,
    input  alu_res_low, alu_res_high, alu_divDone,
    output issue_ready, stall, alu_aluop, alu_a, alu_b,
    output res, res_valid, hi, lo, div_err
  );

  modport master (
    output id_valid, id_aluop, id_a, id_b, id_hilo_we, id_mthi, id_mtlo,
    output alu_res_low, alu_res_high, alu_divDone,
    input  issue_ready, stall, alu_aluop, alu_a, alu_b,
    input  res, res_valid, hi, lo, div_err
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// EX-stage ALU issue controller: single-cycle ops, multi-cycle divide handshake, HI/LO ownership.
// Optional divide watchdog enabled by defining ALU_ISSUE_DIV_TIMEOUT_EN (limit DIV_TIMEOUT).
module alu_issue_ctrl #(
  parameter int DIV_TIMEOUT = 63
) (
  input  logic              clk,
  input  logic              rst,
  alu_issue_ctrl_if.slave   bus
);

  localparam logic [3:0] OpMul = 4'd2;
  localparam logic [3:0] OpDiv = 4'd3;

  typedef enum logic [1:0] {IDLE, DIV_RUN, DIV_GAP} stateE;

  stateE       state, nextState;
  logic [31:0] opA, opB;
  logic        opHiloWe;
  logic [31:0] hiReg, loReg, resReg;
  logic        resValidReg;
  logic        divErr;

  logic [3:0]  aluAluop;
  logic [31:0] aluA, aluB;
  logic        latchOps;
  logic        resLoad;
  logic [31:0] resNext;
  logic        hiWe, loWe;
  logic [31:0] hiNext, loNext;
  logic        timeoutHit;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    nextState = state;
    aluAluop  = 4'd0;
    aluA      = '0;
    aluB      = '0;
    latchOps  = 1'b0;
    resLoad   = 1'b0;
    resNext   = bus.alu_res_low;
    hiWe      = 1'b0;
    loWe      = 1'b0;
    hiNext    = bus.alu_res_high;
    loNext    = bus.alu_res_low;

    unique case (state)
      IDLE: begin
        if (bus.id_valid) begin
          if (bus.id_aluop == OpDiv) begin
            if (bus.id_b == '0) begin
              // Divide by zero resolves in place; the ALU divider is never started.
              resLoad = 1'b1;
              resNext = '1;
              hiWe    = bus.id_hilo_we;
              loWe    = bus.id_hilo_we;
              hiNext  = bus.id_a;
              loNext  = '1;
            end else begin
              latchOps  = 1'b1;
              nextState = DIV_RUN;
            end
          end else begin
            aluAluop = bus.id_aluop;
            aluA     = bus.id_a;
            aluB     = bus.id_b;
            if (bus.id_aluop == OpMul) begin
              resLoad = 1'b1;
              hiWe    = bus.id_hilo_we;
              loWe    = bus.id_hilo_we;
            end else if (bus.id_mthi || bus.id_mtlo) begin
              hiWe   = bus.id_mthi;
              loWe   = bus.id_mtlo;
              hiNext = bus.id_a;
              loNext = bus.id_a;
            end else begin
              resLoad = 1'b1;
            end
          end
        end
      end
      DIV_RUN: begin
        aluAluop = OpDiv;
        aluA     = opA;
        aluB     = opB;
        if (bus.alu_divDone) begin
          resLoad   = 1'b1;
          hiWe      = opHiloWe;
          loWe      = opHiloWe;
          nextState = DIV_GAP;
        end else if (timeoutHit) begin
          nextState = DIV_GAP;
        end
      end
      DIV_GAP: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      hiReg       <= '0;
      loReg       <= '0;
      resReg      <= '0;
      resValidReg <= 1'b0;
    end else begin
      state       <= nextState;
      resValidReg <= resLoad;
      if (resLoad) resReg <= resNext;
      if (hiWe)    hiReg  <= hiNext;
      if (loWe)    loReg  <= loNext;
    end
  end

  // NOTE: operand latches need no reset; they are always written on the accept that enters DIV_RUN.
  always_ff @(posedge clk) begin
    if (latchOps) begin
      opA      <= bus.id_a;
      opB      <= bus.id_b;
      opHiloWe <= bus.id_hilo_we;
    end
  end

`ifdef ALU_ISSUE_DIV_TIMEOUT_EN
  localparam int CntW = $clog2(DIV_TIMEOUT + 1) + 1;

  logic [CntW-1:0] divCnt;

  assign timeoutHit = (divCnt == CntW'(DIV_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (latchOps)               divCnt <= '0;
    else if (state == DIV_RUN)  divCnt <= divCnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst)
      divErr <= 1'b0;
    else if (state == DIV_RUN && !bus.alu_divDone && timeoutHit)
      divErr <= 1'b1;
  end
`else
  assign timeoutHit = 1'b0;
  assign divErr     = 1'b0;
`endif

  assign bus.issue_ready = (state == IDLE);
  assign bus.stall       = (state != IDLE);
  assign bus.alu_aluop   = aluAluop;
  assign bus.alu_a       = aluA;
  assign bus.alu_b       = aluB;
  assign bus.res         = resReg;
  assign bus.res_valid   = resValidReg;
  assign bus.hi          = hiReg;
  assign bus.lo          = loReg;
  assign bus.div_err     = divErr;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural ALU stub (fixed-latency divider).
module tb_alu_issue_ctrl;

  localparam int TimeoutCycles = 8;
  localparam int DivLat        = 4;

  logic clk;
  logic rst;
  alu_issue_ctrl_if bus();

  alu_issue_ctrl #(.DIV_TIMEOUT(TimeoutCycles)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU stub: combinational ops, divider starts on a 0->3 aluop edge and
  // raises divDone DivLat cycles after the start edge.
  logic [63:0] stubProd;
  logic [3:0]  prevOp;
  int          divCnt;
  logic        stubNoDone;

  assign stubProd = {32'd0, bus.alu_a} * {32'd0, bus.alu_b};

  always_ff @(posedge clk) begin
    prevOp <= bus.alu_aluop;
    if (bus.alu_aluop != 4'd3)   divCnt <= 0;
    else if (prevOp != 4'd3)     divCnt <= 1;
    else if (divCnt < DivLat)    divCnt <= divCnt + 1;
  end

  assign bus.alu_divDone = (bus.alu_aluop == 4'd3) && (divCnt == DivLat) && !stubNoDone;

  always_comb begin
    bus.alu_res_low  = '0;
    bus.alu_res_high = '0;
    case (bus.alu_aluop)
      4'd0: bus.alu_res_low = bus.alu_a + bus.alu_b;
      4'd1: bus.alu_res_low = bus.alu_a - bus.alu_b;
      4'd2: {bus.alu_res_high, bus.alu_res_low} = stubProd;
      4'd3: if (bus.alu_b != 0) begin
        bus.alu_res_low  = bus.alu_a / bus.alu_b;
        bus.alu_res_high = bus.alu_a % bus.alu_b;
      end
      4'd4: bus.alu_res_low = bus.alu_a & bus.alu_b;
      4'd5: bus.alu_res_low = bus.alu_a | bus.alu_b;
      4'd6: bus.alu_res_low = bus.alu_a ^ bus.alu_b;
      4'd9: bus.alu_res_low = bus.alu_a << bus.alu_b[4:0];
      4'd10: bus.alu_res_low = bus.alu_a >> bus.alu_b[4:0];
      default: bus.alu_res_low = '0;
    endcase
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic we, input logic mthi, input logic mtlo);
    bus.id_valid   = v;
    bus.id_aluop   = op;
    bus.id_a       = a;
    bus.id_b       = b;
    bus.id_hilo_we = we;
    bus.id_mthi    = mthi;
    bus.id_mtlo    = mtlo;
  endtask

  task automatic doDiv(input logic [31:0] a, input logic [31:0] b, input logic we,
                       input logic [31:0] expHi, input logic [31:0] expLo, input logic [31:0] expRes);
    int runCycles;
    int badRun;
    drive(1'b1, 4'd3, a, b, we, 1'b0, 1'b0);
    #1;
    check("div_accept_aluop", {28'd0, bus.alu_aluop}, 32'd0);
    check("div_accept_ready", {31'd0, bus.issue_ready}, 32'd1);
    step();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    runCycles = 0;
    badRun    = 0;
    while (!bus.res_valid && runCycles < 100) begin
      if (bus.alu_aluop !== 4'd3 || bus.stall !== 1'b1) badRun++;
      runCycles++;
      step();
    end
    check("div_run_len", runCycles, DivLat + 1);
    check("div_run_aluop_stall", badRun, 0);
    check("div_res_valid", {31'd0, bus.res_valid}, 32'd1);
    check("div_lo", bus.lo, expLo);
    check("div_hi", bus.hi, expHi);
    check("div_res", bus.res, expRes);
    check("div_gap_aluop", {28'd0, bus.alu_aluop}, 32'd0);
    check("div_gap_stall", {31'd0, bus.stall}, 32'd1);
    step();
    check("div_idle_ready", {31'd0, bus.issue_ready}, 32'd1);
    check("div_idle_stall", {31'd0, bus.stall}, 32'd0);
    check("div_rv_pulse", {31'd0, bus.res_valid}, 32'd0);
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        we;
    logic        mthi;
    logic        mtlo;
    logic [3:0]  expAluop;
    logic [31:0] expRes;
    logic        expRv;
    logic [31:0] expHi;
    logic [31:0] expLo;
  } vecT;

  vecT vec[13];

  initial begin
    vec[0]  = '{4'd0, 32'd5,        32'd7,        1'b0, 1'b0, 1'b0, 4'd0, 32'd12,         1'b1, 32'd0,     32'd0};
    vec[1]  = '{4'd1, 32'd5,        32'd7,        1'b0, 1'b0, 1'b0, 4'd1, 32'hFFFF_FFFE,  1'b1, 32'd0,     32'd0};
    vec[2]  = '{4'd2, 32'h0001_0000, 32'h0001_0000, 1'b1, 1'b0, 1'b0, 4'd2, 32'd0,       1'b1, 32'd1,     32'd0};
    vec[3]  = '{4'd2, 32'd3,        32'd4,        1'b0, 1'b0, 1'b0, 4'd2, 32'd12,         1'b1, 32'd1,     32'd0};
    vec[4]  = '{4'd4, 32'h0000_F0F0, 32'h0000_FF00, 1'b0, 1'b0, 1'b0, 4'd4, 32'h0000_F000, 1'b1, 32'd1,   32'd0};
    vec[5]  = '{4'd5, 32'h0000_F0F0, 32'h0000_0F0F, 1'b0, 1'b0, 1'b0, 4'd5, 32'h0000_FFFF, 1'b1, 32'd1,   32'd0};
    vec[6]  = '{4'd6, 32'h0000_00FF, 32'h0000_000F, 1'b0, 1'b0, 1'b0, 4'd6, 32'h0000_00F0, 1'b1, 32'd1,   32'd0};
    vec[7]  = '{4'd9, 32'd1,        32'd4,        1'b0, 1'b0, 1'b0, 4'd9, 32'h10,         1'b1, 32'd1,     32'd0};
    vec[8]  = '{4'd0, 32'h0000_AAAA, 32'd1,       1'b0, 1'b1, 1'b0, 4'd0, 32'h10,         1'b0, 32'hAAAA,  32'd0};
    vec[9]  = '{4'd0, 32'h55,       32'd0,        1'b0, 1'b1, 1'b1, 4'd0, 32'h10,         1'b0, 32'h55,    32'h55};
    vec[10] = '{4'd2, 32'd7,        32'd6,        1'b1, 1'b1, 1'b0, 4'd2, 32'd42,         1'b1, 32'd0,     32'd42};
    vec[11] = '{4'd3, 32'd9,        32'd0,        1'b1, 1'b0, 1'b0, 4'd0, 32'hFFFF_FFFF,  1'b1, 32'd9,     32'hFFFF_FFFF};
    vec[12] = '{4'd3, 32'd3,        32'd0,        1'b0, 1'b0, 1'b0, 4'd0, 32'hFFFF_FFFF,  1'b1, 32'd9,     32'hFFFF_FFFF};

    stubNoDone = 1'b0;
    rst = 1'b0;
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    rst = 1'b1;
    #1;
    check("rst_hi", bus.hi, 32'd0);
    check("rst_lo", bus.lo, 32'd0);
    check("rst_res", bus.res, 32'd0);
    check("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
    check("rst_div_err", {31'd0, bus.div_err}, 32'd0);
    check("rst_stall", {31'd0, bus.stall}, 32'd0);
    check("rst_ready", {31'd0, bus.issue_ready}, 32'd1);
    check("rst_alu_aluop", {28'd0, bus.alu_aluop}, 32'd0);
    check("rst_alu_a", bus.alu_a, 32'd0);
    check("rst_alu_b", bus.alu_b, 32'd0);

    for (int i = 0; i < 13; i++) begin
      drive(1'b1, vec[i].op, vec[i].a, vec[i].b, vec[i].we, vec[i].mthi, vec[i].mtlo);
      #1;
      check($sformatf("vec%0d_alu_aluop", i), {28'd0, bus.alu_aluop}, {28'd0, vec[i].expAluop});
      check($sformatf("vec%0d_stall", i), {31'd0, bus.stall}, 32'd0);
      step();
      check($sformatf("vec%0d_res", i), bus.res, vec[i].expRes);
      check($sformatf("vec%0d_res_valid", i), {31'd0, bus.res_valid}, {31'd0, vec[i].expRv});
      check($sformatf("vec%0d_hi", i), bus.hi, vec[i].expHi);
      check($sformatf("vec%0d_lo", i), bus.lo, vec[i].expLo);
    end

    drive(1'b0, 4'd5, 32'h1234, 32'h5678, 1'b0, 1'b0, 1'b0);
    #1;
    check("idle_alu_aluop", {28'd0, bus.alu_aluop}, 32'd0);
    check("idle_alu_a", bus.alu_a, 32'd0);
    step();
    check("idle_res_valid", {31'd0, bus.res_valid}, 32'd0);

    doDiv(32'd100, 32'd7, 1'b1, 32'd2, 32'd14, 32'd14);
    doDiv(32'd50, 32'd5, 1'b1, 32'd0, 32'd10, 32'd10);
    doDiv(32'd20, 32'd3, 1'b0, 32'd0, 32'd10, 32'd6);

    drive(1'b1, 4'd3, 32'd100, 32'd7, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    step();
    check("mid_div_stall", {31'd0, bus.stall}, 32'd1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    #1;
    check("mid_rst_stall", {31'd0, bus.stall}, 32'd0);
    check("mid_rst_ready", {31'd0, bus.issue_ready}, 32'd1);
    check("mid_rst_hi", bus.hi, 32'd0);
    check("mid_rst_lo", bus.lo, 32'd0);
    check("mid_rst_res", bus.res, 32'd0);
    check("mid_rst_alu_aluop", {28'd0, bus.alu_aluop}, 32'd0);
    doDiv(32'd50, 32'd5, 1'b1, 32'd0, 32'd10, 32'd10);

`ifdef ALU_ISSUE_DIV_TIMEOUT_EN
    begin
      int runCycles;
      stubNoDone = 1'b1;
      drive(1'b1, 4'd3, 32'd40, 32'd3, 1'b1, 1'b0, 1'b0);
      step();
      drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
      runCycles = 0;
      while (!bus.div_err && runCycles < 200) begin
        runCycles++;
        step();
      end
      check("to_run_len", runCycles, TimeoutCycles);
      check("to_div_err", {31'd0, bus.div_err}, 32'd1);
      check("to_res_valid", {31'd0, bus.res_valid}, 32'd0);
      check("to_lo", bus.lo, 32'd10);
      check("to_hi", bus.hi, 32'd0);
      check("to_gap_stall", {31'd0, bus.stall}, 32'd1);
      check("to_gap_aluop", {28'd0, bus.alu_aluop}, 32'd0);
      step();
      check("to_idle_stall", {31'd0, bus.stall}, 32'd0);
      check("to_err_sticky", {31'd0, bus.div_err}, 32'd1);
      stubNoDone = 1'b0;
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
